// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive blocks on this link.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 143;
    localparam int UART_DATA_BITS            = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 serialiser: latches din on start and shifts it out LSB first.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [UART_DATA_BITS-1:0] din,
    output logic                      busy,
    output logic                      tx
);

    localparam int                CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam int                BW       = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0]     BIT_LAST = BW'(UART_DATA_BITS - 1);

    uart_state_e               state_q;
    logic [CW-1:0]             cnt_q;
    logic [BW-1:0]             bit_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      tx_q;
    logic                      busy_q;
    logic                      cnt_done_s;

    assign cnt_done_s = (cnt_q == CNT_LAST);

    // Frame state machine; tx and busy are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        shift_q <= din;
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_done_s) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + CW'(1'b1);
                    end
                end
                ST_DATA: begin
                    if (cnt_done_s) begin
                        cnt_q   <= '0;
                        shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + BW'(1'b1);
                            // Present the next bit now so tx stays a pure register output.
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1'b1);
                    end
                end
                ST_STOP: begin
                    if (cnt_done_s) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1'b1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign tx   = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmit line between N_REQ byte sources.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int N_REQ        = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int            IW        = $clog2(N_REQ);
    localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);
    localparam logic [IW:0]   N_WIDE    = (IW+1)'(N_REQ);

    logic [IW-1:0]             last_q;
    logic [IW-1:0]             grant_id_q;
    logic                      en_q;
    logic [IW:0]               cand_s;
    logic                      pick_valid_s;
    logic [IW-1:0]             pick_idx_s;
    logic [N_REQ-1:0]          ready_s;
    logic                      start_s;
    logic [UART_DATA_BITS-1:0] din_s;
    logic                      ser_busy_s;

    // First valid requester searching upward from last+1 with wrap.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = {1'b0, last_q} + (IW+1)'(k);
            cand_s = (cand_s >= N_WIDE) ? (cand_s - N_WIDE) : cand_s;
            if (!pick_valid_s && req_valid[cand_s[IW-1:0]]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = cand_s[IW-1:0];
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // One-hot accept pulse, only while the line is idle; en_q masks it during and just after reset.
    always_comb begin
        ready_s = '0;
        if (en_q && !ser_busy_s && pick_valid_s) begin
            ready_s[pick_idx_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign start_s = |ready_s;
    assign din_s   = req_data[{pick_idx_s, 3'b000} +: UART_DATA_BITS];

    // Round-robin pointer and reported grant index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            last_q     <= LAST_INIT;
            grant_id_q <= '0;
        end else begin
            en_q <= 1'b1;
            if (start_s) begin
                last_q     <= pick_idx_s;
                grant_id_q <= pick_idx_s;
            end else begin
                last_q     <= last_q;
                grant_id_q <= grant_id_q;
            end
        end
    end

    uart_tx_ser #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_s),
        .din   (din_s),
        .busy  (ser_busy_s),
        .tx    (tx)
    );

    assign req_ready = ready_s;
    assign busy      = ser_busy_s;
    assign grant_id  = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line between up to N byte-stream requesters. Round-robin arbitration per frame; the granted byte is serialised as 8N1 (start, 8 data bits LSB first, stop). Sits opposite the `uart_rx` receiver on the same link, at the same bit timing of 143 clocks per bit.

## Interface
- `CLKS_PER_BIT`, 143, clocks per UART bit; must be ≥ 2.
- `N_REQ`, 4, number of requesters; range 2..8.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester byte-available flag.
- `req_data`  in  8*N_REQ  requester i's byte is at [8*i+7 : 8*i].
- `req_ready`  out  N_REQ  one-hot, single-cycle accept pulse.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is being sent.
- `grant_id`  out  $clog2(N_REQ)  index of the last-granted requester.

## Operation
- States:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=shift[0].
  - STOP: `tx`=1.
- IDLE:
  - If any `req_valid` is high, pick the first valid index searching from `(last+1) mod N_REQ` upward with wrap.
  - Assert that requester's `req_ready` for exactly this cycle; the transfer is the cycle where `req_valid & req_ready`.
  - Latch its `req_data` into the shift register and set `grant_id`/`last` to that index. Go to START.
  - If no request is valid, stay in IDLE.
- START: hold for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - After each bit, shift right and increment the index.
  - After bit 7 completes, go to STOP.
- STOP: hold for CLKS_PER_BIT cycles, then go to IDLE.
- `busy` = (state != IDLE).
- Bit counter: $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1 and reloads 0 on every state or bit change.
- `req_valid` may drop before it is granted; this has no effect. Data is sampled only in the accept cycle and may change afterwards.
- Requests arriving while `busy` wait; they are evaluated in the next IDLE cycle.
- Simultaneous requests: round-robin order only. No requester is granted twice while another valid requester is waiting.
- A requester holding `req_valid` continuously gets every N_REQ-th frame when all requesters are active.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0, state IDLE, shift register=0.
  - `last`=N_REQ-1, so requester 0 has first priority after reset.
- Accept at cycle T (IDLE, `req_ready` high):
  - `tx` falls and `busy` rises at T+1.
  - Data bit k occupies cycles T+1+(k+1)·CLKS_PER_BIT .. +CLKS_PER_BIT-1.
  - Stop bit starts at T+1+9·CLKS_PER_BIT.
  - IDLE is re-entered at T+1+10·CLKS_PER_BIT.
- Back-to-back frames: the earliest next accept is the IDLE-entry cycle. This gives exactly one idle-high clock between a stop bit and the next start bit, so the minimum frame period is 10·CLKS_PER_BIT+1 cycles.
- Reset asserted mid-frame: `tx` returns high and `req_ready` drops asynchronously. The frame is abandoned with no resume, and arbitration restarts from requester 0.
- `tx` is driven directly from a register; no combinational path from inputs to `tx`.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE, START, DATA, STOP).
  - `UART_CLKS_PER_BIT_DEFAULT` = 143, also used by `uart_rx`.
  - `UART_DATA_BITS` = 8.
- Sub-module `uart_tx_ser`:
  - Owns the state machine, bit counter and shift register.
  - Handshake: `start`/`din[7:0]` in, `busy`/`tx` out.
- The top level holds only the round-robin pointer, grant logic and `req_ready`/`grant_id` generation.

## Test plan
- Reset only: `tx`=1, `busy`=0, `req_ready`=0 for 100 cycles; then release `rst_n` → no change.
- Single request: req 2 sends 0xA5.
  - `req_ready[2]` pulses once.
  - `tx` reads 0,1,0,1,0,0,1,0,1,1, each for 143 cycles (CLKS_PER_BIT=143).
  - A looped-back `uart_rx` reports data=0xA5.
- All four valid continuously with bytes 0x10..0x13:
  - Grant order is 0,1,2,3,0.
  - Frame starts are 1431 cycles apart.
- Fairness: req 1 valid constantly, req 3 raised mid-frame → req 3 is granted at the next IDLE before req 1 repeats.
- Valid withdrawn: req 0 pulses valid for 1 cycle during `busy` → never granted, `tx` stays idle afterwards.
- Reset mid-frame: assert `rst_n`=0 during data bit 4, hold 5 cycles.
  - `tx`=1 immediately; `busy`=0.
  - After release, a new req 0 frame transmits correctly.
